// File: rtl/eco32f_divider_pkg.sv
// Shared encodings for the eco32f iterative divider: FSM states, iteration
// count, exception cause code and a magnitude helper.
package eco32f_divider_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_ITERS      = 32;
  localparam logic [4:0]  DIV_COUNT_INIT = 5'(DIV_ITERS - 1);

  // Cause code merged into the execute exception vector on divide-by-zero.
  localparam logic [4:0]  EXC_CAUSE_DIV_ZERO = 5'd10;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/eco32f_divider.sv
// Iterative restoring 32-bit divider for the eco32f execute stage. Stalls the
// pipeline while running, then presents quotient or remainder for one cycle.
module eco32f_divider
  import eco32f_divider_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_op_div,
  input  logic        ex_op_rem,
  input  logic        ex_signed_div,
  input  logic [31:0] ex_op_a,
  input  logic [31:0] ex_op_b,
  input  logic        ex_flush,
  output logic        ex_div_stall,
  output logic        ex_div_valid,
  output logic [31:0] ex_div_result,
  output logic        ex_exc_div_zero
);

  div_state_t  state_reg, state_next;
  logic [31:0] quo_reg, quo_next;
  logic [31:0] rem_reg, rem_next;
  logic [31:0] div_reg, div_next;
  logic [31:0] result_reg, result_next;
  logic [4:0]  count_reg, count_next;
  logic        neg_q_reg, neg_q_next;
  logic        neg_r_reg, neg_r_next;
  logic        want_rem_reg, want_rem_next;
  logic        div_zero_reg, div_zero_next;

  logic        start;
  logic [32:0] trial;
  logic [31:0] step_quo, step_rem;
  logic [31:0] neg_in, final_value;
  logic        neg_sel;

  assign start = (state_reg == DIV_IDLE) & (ex_op_div | ex_op_rem) & ~ex_flush;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign trial = {rem_reg, quo_reg[31]} - {1'b0, div_reg};

  always_comb begin
    if (!trial[32]) begin
      step_rem = trial[31:0];
      step_quo = {quo_reg[30:0], 1'b1};
    end else begin
      step_rem = {rem_reg[30:0], quo_reg[31]};
      step_quo = {quo_reg[30:0], 1'b0};
    end
  end

  // Single shared negator for the sign fix-up of whichever value is returned.
  assign neg_in      = want_rem_reg ? step_rem : step_quo;
  assign neg_sel     = want_rem_reg ? neg_r_reg : neg_q_reg;
  assign final_value = neg_sel ? -neg_in : neg_in;

  always_comb begin
    state_next    = state_reg;
    quo_next      = quo_reg;
    rem_next      = rem_reg;
    div_next      = div_reg;
    result_next   = result_reg;
    count_next    = count_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    want_rem_next = want_rem_reg;
    div_zero_next = div_zero_reg;

    if (ex_flush) begin
      state_next    = DIV_IDLE;
      quo_next      = '0;
      rem_next      = '0;
      div_next      = '0;
      result_next   = '0;
      count_next    = '0;
      neg_q_next    = 1'b0;
      neg_r_next    = 1'b0;
      want_rem_next = 1'b0;
      div_zero_next = 1'b0;
    end else begin
      unique case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            if (ex_op_b == '0) begin
              state_next    = DIV_DONE;
              div_zero_next = 1'b1;
              result_next   = '0;
            end else begin
              state_next    = DIV_RUN;
              quo_next      = abs32(ex_op_a, ex_signed_div);
              div_next      = abs32(ex_op_b, ex_signed_div);
              rem_next      = '0;
              count_next    = DIV_COUNT_INIT;
              neg_q_next    = (ex_op_a[31] ^ ex_op_b[31]) & ex_signed_div;
              neg_r_next    = ex_op_a[31] & ex_signed_div;
              want_rem_next = ex_op_rem;
              div_zero_next = 1'b0;
            end
          end
        end
        DIV_RUN: begin
          quo_next   = step_quo;
          rem_next   = step_rem;
          count_next = count_reg - 5'd1;
          if (count_reg == '0) begin
            state_next  = DIV_DONE;
            result_next = final_value;
          end
        end
        DIV_DONE: begin
          state_next    = DIV_IDLE;
          div_zero_next = 1'b0;
        end
        default: state_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= DIV_IDLE;
      quo_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      result_reg   <= '0;
      count_reg    <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      want_rem_reg <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      quo_reg      <= quo_next;
      rem_reg      <= rem_next;
      div_reg      <= div_next;
      result_reg   <= result_next;
      count_reg    <= count_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      want_rem_reg <= want_rem_next;
      div_zero_reg <= div_zero_next;
    end
  end

  assign ex_div_stall    = start | (state_reg == DIV_RUN);
  assign ex_div_valid    = (state_reg == DIV_DONE) & ~ex_flush;
  assign ex_exc_div_zero = ex_div_valid & div_zero_reg;
  assign ex_div_result   = result_reg;

endmodule

// File: tb/tb_eco32f_divider.sv
// Directed self-checking bench for eco32f_divider: results, latency, stall
// length, divide-by-zero, flush/reset aborts and back-to-back operation.
module tb_eco32f_divider;

  logic        clk;
  logic        rst;
  logic        ex_op_div;
  logic        ex_op_rem;
  logic        ex_signed_div;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;
  logic        ex_flush;
  logic        ex_div_stall;
  logic        ex_div_valid;
  logic [31:0] ex_div_result;
  logic        ex_exc_div_zero;

  int checks   = 0;
  int failures = 0;

  eco32f_divider dut (
    .clk             (clk),
    .rst             (rst),
    .ex_op_div       (ex_op_div),
    .ex_op_rem       (ex_op_rem),
    .ex_signed_div   (ex_signed_div),
    .ex_op_a         (ex_op_a),
    .ex_op_b         (ex_op_b),
    .ex_flush        (ex_flush),
    .ex_div_stall    (ex_div_stall),
    .ex_div_valid    (ex_div_valid),
    .ex_div_result   (ex_div_result),
    .ex_exc_div_zero (ex_exc_div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Runs one operation and checks stall length, latency, result, exception
  // and the one-cycle valid pulse. Returns one cycle after DONE, in IDLE.
  task automatic do_op(input string tag, input logic d, input logic r, input logic s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
    int lat;
    int stalls;
    @(negedge clk);
    ex_op_div = d; ex_op_rem = r; ex_signed_div = s; ex_op_a = a; ex_op_b = b;
    #1;
    chk({tag, "_stall_start"}, 32'(ex_div_stall), 32'd1);
    stalls = 1;
    @(posedge clk); #1;
    lat = 1;
    // Operands must have been captured already.
    ex_op_a = ~a;
    ex_op_b = b ^ 32'h5;
    while (!ex_div_valid && lat < 40) begin
      stalls += ex_div_stall ? 1 : 0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_lat));
    chk({tag, "_result"}, ex_div_result, exp_res);
    chk({tag, "_exc"}, 32'(ex_exc_div_zero), 32'(exp_exc));
    chk({tag, "_stall_done"}, 32'(ex_div_stall), 32'd0);
    ex_op_div = 1'b0; ex_op_rem = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_valid_pulse"}, 32'(ex_div_valid), 32'd0);
    $display("op %s a=%h b=%h result=%h exc=%0d lat=%0d", tag, a, b, exp_res, exp_exc, lat);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; ex_op_div = 1'b0; ex_op_rem = 1'b0; ex_signed_div = 1'b0;
    ex_op_a = '0; ex_op_b = '0; ex_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(ex_div_stall), 32'd0);
    chk("rst_valid", 32'(ex_div_valid), 32'd0);
    chk("rst_exc", 32'(ex_exc_div_zero), 32'd0);
    chk("rst_result", ex_div_result, 32'd0);
    rst = 1'b0;

    do_op("divu_100_7", 1, 0, 0, 32'd100, 32'd7, 32'd14, 0, 33);
    do_op("remu_100_7", 0, 1, 0, 32'd100, 32'd7, 32'd2, 0, 33);
    do_op("div_m7_2", 1, 0, 1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0, 33);
    do_op("rem_m7_2", 0, 1, 1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 0, 33);
    do_op("div_7_m2", 1, 0, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 0, 33);
    do_op("rem_7_m2", 0, 1, 1, 32'd7, 32'hFFFFFFFE, 32'd1, 0, 33);
    do_op("div_zero", 1, 0, 1, 32'd5, 32'd0, 32'd0, 1, 1);
    do_op("remu_zero", 0, 1, 0, 32'd77, 32'd0, 32'd0, 1, 1);
    do_op("div_ovf", 1, 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 33);
    do_op("rem_ovf", 0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0, 33);
    do_op("divu_max_1", 1, 0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 0, 33);

    // Flush on the 10th RUN cycle.
    @(negedge clk);
    ex_op_div = 1'b1; ex_signed_div = 1'b0; ex_op_a = 32'd1000; ex_op_b = 32'd3;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush_stall_run", 32'(ex_div_stall), 32'd1);
    ex_flush = 1'b1; ex_op_div = 1'b0;
    @(posedge clk); #1;
    ex_flush = 1'b0;
    chk("flush_stall_after", 32'(ex_div_stall), 32'd0);
    chk("flush_result_cleared", ex_div_result, 32'd0);
    pulses = 0;
    repeat (40) begin pulses += ex_div_valid ? 1 : 0; @(posedge clk); #1; end
    chk("flush_no_valid", 32'(pulses), 32'd0);
    $display("op flush_mid_run pulses=%0d", pulses);
    do_op("divu_50_5_after_flush", 1, 0, 0, 32'd50, 32'd5, 32'd10, 0, 33);

    // Reset mid-RUN.
    @(negedge clk);
    ex_op_div = 1'b1; ex_op_a = 32'd1000; ex_op_b = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1; ex_op_div = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_stall", 32'(ex_div_stall), 32'd0);
    chk("rst_mid_result", ex_div_result, 32'd0);
    pulses = 0;
    repeat (40) begin pulses += ex_div_valid ? 1 : 0; @(posedge clk); #1; end
    chk("rst_mid_no_valid", 32'(pulses), 32'd0);
    $display("op reset_mid_run pulses=%0d", pulses);
    do_op("divu_50_5_after_rst", 1, 0, 0, 32'd50, 32'd5, 32'd10, 0, 33);

    // Back-to-back: second op is presented in the first IDLE cycle after DONE.
    do_op("b2b_div", 1, 0, 1, 32'd1000, 32'hFFFFFFF9, 32'hFFFFFF72, 0, 33);
    do_op("b2b_remu", 0, 1, 0, 32'd123456789, 32'd1000, 32'd789, 0, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eco32f_divider.md
# eco32f_divider

Iterative 32-bit integer divider for the eco32f execute stage, serving DIV/DIVI/DIVU/DIVUI and REM/REMI/REMU/REMUI. It is started by the registered `ex_op_div`/`ex_op_rem` controls from decode. While dividing it holds the pipeline through a stall output, then delivers quotient or remainder for one cycle. Divide-by-zero raises an exception instead of producing a result.

## Interface
- Parameters: none; datapath fixed at 32 bits, 32 iterations.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `ex_op_div` in 1: quotient requested by the instruction in execute.
- `ex_op_rem` in 1: remainder requested by the instruction in execute.
- `ex_signed_div` in 1: signed operation.
- `ex_op_a` in 32: dividend, forwarded operand x.
- `ex_op_b` in 32: divisor, forwarded operand y or immediate.
- `ex_flush` in 1: abort current operation.
- `ex_div_stall` out 1: execute and earlier stages must hold.
- `ex_div_valid` out 1: `ex_div_result` valid this cycle.
- `ex_div_result` out 32: quotient or remainder.
- `ex_exc_div_zero` out 1: divide-by-zero exception, qualified by `ex_div_valid`.

## Operation
- FSM states: IDLE, RUN, DONE.
- `start` = IDLE & (`ex_op_div` | `ex_op_rem`) & !`ex_flush`.
- IDLE, `start` & `ex_op_b` != 0: latch operands, go to RUN with `count` = 31.
  - Latch |a| and |b| when signed, else raw values.
  - Latch `neg_q` = a[31]^b[31] & signed and `neg_r` = a[31] & signed.
  - Latch `want_rem` = `ex_op_rem`.
- IDLE, `start` & `ex_op_b` == 0: go to DONE with `div_zero` = 1.
- RUN, each cycle, restoring step:
  - trial = {rem[31:0], quo[31]} − {1'b0, div} (33-bit).
  - trial[32] == 0: rem = trial[31:0], quo = {quo[30:0], 1}.
  - Otherwise: rem = {rem[30:0], quo[31]}, quo = {quo[30:0], 0}.
  - quo is initialised with the dividend; rem is initialised to 0.
  - `count` decrements each step; at `count` == 0, go to DONE.
- DONE: `ex_div_valid` = 1.
  - `ex_div_result` = `want_rem` ? (`neg_r` ? −rem : rem) : (`neg_q` ? −quo : quo).
  - When `div_zero`, the result is 0 and `ex_exc_div_zero` = 1.
  - Next state is always IDLE. The pipeline advances at the end of DONE, so the stale op is never restarted.
- Signed semantics truncate toward zero; the remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000 and remainder 0, with no exception.
- `ex_flush` in any state: IDLE next cycle, no `ex_div_valid`, all registers cleared. `ex_flush` overrides `start`.
- Reset: state IDLE; `ex_div_stall`, `ex_div_valid`, `ex_exc_div_zero` = 0; `ex_div_result` = 0.

## Timing
- `ex_div_stall` = `start` | (state == RUN). It is combinational from the ex_op inputs, so it is asserted in the start cycle.
- It is low in DONE and in IDLE when no op is pending.
- Non-zero divisor: start cycle T, RUN T+1..T+32, DONE T+33.
  - Stall high T..T+32 (33 cycles).
  - Result registered and valid at T+33.
- Zero divisor: stall in T only; DONE with exception at T+1.
- Back-to-back divides: a second op presented at T+34 starts immediately; no idle gap is required.
- Operands are sampled only in the start cycle; later changes on `ex_op_a`/`ex_op_b` are ignored.
- `ex_div_result` holds its last value outside DONE. Consumers qualify it with `ex_div_valid`.

## Structure
- Add to `eco32f.vh`:
  - `ECO32F_DIV_IDLE`/`RUN`/`DONE` 2-bit encodings.
  - `ECO32F_DIV_ITERS` = 32.
  - An exception cause code for divide-by-zero.
- Single module with no sub-module. The step logic is one 33-bit subtractor; the two output negations share one 32-bit negate muxed ahead of it.
- Instantiated in execute. Its stall is ORed into the global pipeline stall, and its exception is merged into the execute exception vector.

## Test plan
- Unsigned 100 / 7:
  - DIVU → result 14, REMU → result 2.
  - Valid exactly 33 cycles after start; stall high for 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002):
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - Signed 7 / −2 → 0xFFFFFFFD, remainder 1.
- Divisor 0 (DIV and REMU):
  - Stall one cycle.
  - Next cycle `ex_div_valid` = 1, `ex_exc_div_zero` = 1, result 0.
- Overflow case 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0, no exception.
  - Unsigned 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Abort cases:
  - `ex_flush` on the 10th RUN cycle → IDLE next cycle, stall drops, no valid pulse.
  - A new DIVU 50 / 5 presented afterwards → 10.
  - `rst` mid-RUN gives the same clean restart.
- Back-to-back DIV then REM with different operands: each result is correct and valid for one cycle, with a zero-cycle gap between the two operations.
